// File: rtl/memory_controller_if.sv
// Bundles the fetch, load, store and byte-wide RAM signals of the memory controller.
// master is the requester/RAM side; slave is the controller.
interface memory_controller_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic [1:0]  ld_width;
    logic        ld_signed;
    logic        ld_done;
    logic [31:0] ld_data;

    logic        st_req;
    logic [31:0] st_addr;
    logic [1:0]  st_width;
    logic [31:0] st_data;
    logic        st_done;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport master (
        output if_req, if_addr, ld_req, ld_addr, ld_width, ld_signed,
               st_req, st_addr, st_width, st_data, mem_din, io_buffer_full,
        input  if_done, if_data, ld_done, ld_data, st_done, mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr, ld_width, ld_signed,
               st_req, st_addr, st_width, st_data, mem_din, io_buffer_full,
        output if_done, if_data, ld_done, ld_data, st_done, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/memory_controller.sv
// Byte-serial memory controller arbitrating store > load > fetch onto a byte-wide RAM
// with one-cycle read latency; supports flush (roll_back) and a global ready stall.
module memory_controller #(
    parameter logic [1:0] IO_REGION = 2'b11
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               roll_back,
    memory_controller_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StLoad, StStore} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [1:0]  width_q, width_d;
    logic        sgn_q, sgn_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        wr_q, wr_d;
    logic        if_done_q, if_done_d;
    logic        ld_done_q, ld_done_d;
    logic        st_done_q, st_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ld_data_q, ld_data_d;

    // The RAM keeps reading the frozen address during a stall, so the byte that was on
    // mem_din when the stall began is parked here and replayed on the resume cycle.
    logic        stall_q;
    logic [7:0]  hold_q;
    logic [7:0]  din;
    logic [31:0] rd_word;
    logic        io_blocked;

    function automatic logic [2:0] nbytes(input logic [1:0] width);
        case (width)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] width,
                                           input logic sgn);
        case (width)
            2'd0:    extend = {{24{sgn & w[7]}}, w[7:0]};
            2'd1:    extend = {{16{sgn & w[15]}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    always_comb begin
        din = stall_q ? hold_q : bus.mem_din;
        rd_word = rbuf_q;
        for (int k = 0; k < 4; k++) begin
            if (cnt_q == 3'(k + 1)) rd_word[8*k +: 8] = din;
        end
    end

    assign io_blocked = bus.st_req && !st_done_q && (bus.st_addr[17:16] == IO_REGION) &&
                        bus.io_buffer_full;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nbytes_d   = nbytes_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        rbuf_d     = rbuf_q;
        width_d    = width_q;
        sgn_d      = sgn_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        wr_d       = wr_q;
        if_data_d  = if_data_q;
        ld_data_d  = ld_data_q;
        if_done_d  = 1'b0;
        ld_done_d  = 1'b0;
        st_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 3'd0;
                if (bus.st_req && !st_done_q) begin
                    if (!io_blocked) begin
                        state_d    = StStore;
                        addr_d     = bus.st_addr;
                        sdata_d    = bus.st_data;
                        nbytes_d   = nbytes(bus.st_width);
                        mem_a_d    = bus.st_addr;
                        mem_dout_d = bus.st_data[7:0];
                        wr_d       = 1'b1;
                    end
                end else if (!roll_back && bus.ld_req && !ld_done_q) begin
                    state_d  = StLoad;
                    addr_d   = bus.ld_addr;
                    nbytes_d = nbytes(bus.ld_width);
                    width_d  = bus.ld_width;
                    sgn_d    = bus.ld_signed;
                    mem_a_d  = bus.ld_addr;
                    rbuf_d   = 32'd0;
                end else if (!roll_back && bus.if_req && !if_done_q) begin
                    state_d  = StFetch;
                    addr_d   = bus.if_addr;
                    nbytes_d = 3'd4;
                    mem_a_d  = bus.if_addr;
                    rbuf_d   = 32'd0;
                end
            end
            StFetch, StLoad: begin
                if (roll_back) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                    mem_a_d = 32'd0;
                end else begin
                    rbuf_d = rd_word;
                    if (cnt_q == nbytes_q) begin
                        state_d = StIdle;
                        cnt_d   = 3'd0;
                        mem_a_d = 32'd0;
                        if (state_q == StFetch) begin
                            if_data_d = rd_word;
                            if_done_d = 1'b1;
                        end else begin
                            ld_data_d = extend(rd_word, width_q, sgn_q);
                            ld_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if ((cnt_q + 3'd1) < nbytes_q) begin
                            mem_a_d = addr_q + {29'd0, cnt_q} + 32'd1;
                        end
                    end
                end
            end
            StStore: begin
                if (cnt_q == nbytes_q - 3'd1) begin
                    state_d    = StIdle;
                    cnt_d      = 3'd0;
                    mem_a_d    = 32'd0;
                    mem_dout_d = 8'd0;
                    wr_d       = 1'b0;
                    st_done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    mem_a_d = addr_q + {29'd0, cnt_q} + 32'd1;
                    for (int k = 0; k < 4; k++) begin
                        if (cnt_q + 3'd1 == 3'(k)) mem_dout_d = sdata_q[8*k +: 8];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            nbytes_q   <= 3'd0;
            addr_q     <= 32'd0;
            sdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            width_q    <= 2'd0;
            sgn_q      <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ld_data_q  <= 32'd0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            rbuf_q     <= rbuf_d;
            width_q    <= width_d;
            sgn_q      <= sgn_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            wr_q       <= wr_d;
            if_done_q  <= if_done_d;
            ld_done_q  <= ld_done_d;
            st_done_q  <= st_done_d;
            if_data_q  <= if_data_d;
            ld_data_q  <= ld_data_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_q <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            stall_q <= !rdy_in;
            if (!rdy_in && !stall_q) hold_q <= bus.mem_din;
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = wr_q & rdy_in;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ld_done  = ld_done_q;
    assign bus.ld_data  = ld_data_q;
    assign bus.st_done  = st_done_q;

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have ports: clk_in  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: rst_in  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: rdy_in  in  1  ready; low freezes the block.
REQ-004 SHALL have: roll_back  in  1  misprediction flush.
REQ-005 SHALL have: if_req in 1, if_addr in 32, if_done out 1, if_data out 32  (instruction fetch, always 4 bytes).
REQ-006 SHALL have: ld_req in 1, ld_addr in 32, ld_width in 2 (0 byte, 1 half, 2 word), ld_signed in 1, ld_done out 1, ld_data out 32  (LSB load).
REQ-007 SHALL have: st_req in 1, st_addr in 32, st_width in 2, st_data in 32, st_done out 1  (LSB committed store).
REQ-008 SHALL have: mem_din in 8, mem_dout out 8, mem_a out 32, mem_wr out 1, io_buffer_full in 1  (byte-wide RAM port).
REQ-009 SHALL have parameter IO_REGION, default 2'b11, meaning addr[17:16] value marking IO space.

Function
REQ-010 SHALL run FSM states IDLE, FETCH, LOAD, STORE; one transaction at a time.
REQ-011 In IDLE, arbitration SHALL be st_req > ld_req > if_req, sampled each cycle; requests are level-held until the matching done.
REQ-012 A requester whose done is high in a cycle SHALL NOT be granted in that cycle.
REQ-013 Byte count N SHALL be 1/2/4 for width 0/1/2; width 3 treated as 4; fetch N=4.
REQ-014 Byte k address SHALL be addr+k, 32-bit, wrapping modulo 2^32; little-endian ordering.
REQ-015 Read: grant edge ending cycle n sets mem_a=addr; byte k address presented in cycle n+1+k; mem_din holds byte k in cycle n+2+k.
REQ-016 Read completion: last byte captured at end of cycle n+1+N; done high for exactly cycle n+2+N with data valid; state IDLE in that cycle.
REQ-017 Load data SHALL be zero- or sign-extended from bit 8N-1 per ld_signed; if_data never extended.
REQ-018 Store: grant edge sets mem_a=addr, mem_dout=st_data[7:0], mem_wr=1; byte k driven in cycle n+1+k; mem_wr=0 from cycle n+1+N; st_done high for exactly cycle n+1+N.
REQ-019 mem_wr SHALL be 1 only during STORE byte cycles; mem_dout SHALL be 0 when not storing.
REQ-020 Store with st_addr[17:16]==IO_REGION and io_buffer_full high SHALL not be granted; controller stays IDLE, blocks load/fetch grants, retries each cycle.
REQ-021 roll_back in FETCH or LOAD SHALL return to IDLE next edge, mem_a=0, no done issued; a done pending in that cycle SHALL be forced low next cycle.
REQ-022 roll_back SHALL NOT affect STORE or st_done; store completes normally.
REQ-023 roll_back in IDLE SHALL suppress grant of ld_req/if_req that cycle; st_req still grantable.
REQ-024 rdy_in low SHALL hold all state, counters and outputs, except mem_wr forced 0; resumes at same byte when rdy_in returns high.
REQ-025 Done outputs SHALL be registered single-cycle pulses; at most one done high per cycle.

Reset
REQ-026 rst_in high at a rising edge SHALL set state IDLE, byte counter 0, all data/address outputs 0, mem_wr 0, all done 0, regardless of rdy_in or roll_back.
REQ-027 Reset mid-transaction SHALL abandon it without any done; an interrupted store is not resumed.

Verification
REQ-028 Fetch if_addr=0x100, RAM bytes 13,05,00,00 -> if_done high exactly 6 cycles after request cycle, if_data=0x00000513.
REQ-029 Load width 0 signed at byte 0x80 -> ld_data=0xFFFFFF80, ld_done 3 cycles after request; unsigned -> 0x00000080.
REQ-030 st_req and if_req asserted same cycle, st 0x11223344 word at 0x200 -> writes 44,33,22,11 to 0x200..0x203 with mem_wr high 4 cycles, st_done, then fetch granted.
REQ-031 Load in progress, roll_back at byte 2 -> IDLE next edge, no ld_done; concurrent store unaffected in separate run.
REQ-032 Store byte to 0x30000 with io_buffer_full high 5 cycles -> mem_wr stays 0 for those cycles, write occurs after deassertion, ld_req blocked meanwhile.
REQ-033 rdy_in low 3 cycles mid-fetch -> mem_a frozen, if_done delayed exactly 3 cycles, data unchanged.
